// File: rtl/net_bus_pkg.sv
// Shared NetBus definitions: header layout, frame type codes, broadcast
// address, word width helper and the receive frame FSM state type.
package net_bus_pkg;

  localparam int unsigned DEST_LSB = 0;
  localparam int unsigned SRC_LSB  = 4;
  localparam int unsigned TYPE_LSB = 8;
  localparam int unsigned RSVD_LSB = 10;
  localparam int unsigned HDR_BITS = 14;

  localparam logic [1:0] TYPE_SINGLE = 2'b00;
  localparam logic [1:0] TYPE_FIRST  = 2'b01;
  localparam logic [1:0] TYPE_MIDDLE = 2'b10;
  localparam logic [1:0] TYPE_LAST   = 2'b11;

  localparam logic [3:0] BROADCAST_ID = 4'hF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } frame_state_e;

  // Bus word width: 14-bit header plus DATA_WIDTH 9-bit lanes.
  function automatic int unsigned word_width(input int unsigned data_width);
    return data_width * 9 + HDR_BITS;
  endfunction

endpackage

// File: rtl/net_bus_fifo.sv
// First-word-fall-through FIFO with registered pointers. Full/empty come
// from an extra pointer MSB. RDATA holds the last head word while empty.
module net_bus_fifo #(
  parameter int unsigned WIDTH = 50,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? last_q : mem[rd_ptr[AW-1:0]];

  // Pointer update; wrap is natural over AW+1 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Remember the current head so RDATA keeps its last value once empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
    end else if (!empty) begin
      last_q <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: rtl/net_bus_rx_node.sv
// NetBus receive endpoint: address filter, frame sequencing FSM, saturating
// protocol-error counter and READY generation in front of an FWFT FIFO.
module net_bus_rx_node
  import net_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter logic [3:0]  NODE_ID    = 4'd0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                                CLK,
  input  logic                                RSTN,
  input  logic [word_width(DATA_WIDTH)-1:0]   DATA,
  input  logic                                VALID,
  output logic                                READY,
  output logic [word_width(DATA_WIDTH)-1:0]   RDATA,
  output logic                                RVALID,
  input  logic                                RREADY,
  output logic [7:0]                          ERR_CNT,
  output logic [$clog2(FIFO_DEPTH):0]         LEVEL
);

  localparam int unsigned WW = word_width(DATA_WIDTH);

  frame_state_e state_q;
  frame_state_e state_d;
  logic [3:0]   dest;
  logic [1:0]   wtype;
  logic         match;
  logic         orphan;
  logic         trunc;
  logic         handshake;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic [7:0]   err_q;

  assign dest  = DATA[DEST_LSB +: 4];
  assign wtype = DATA[TYPE_LSB +: 2];
  assign match = VALID && ((dest == NODE_ID) || (dest == BROADCAST_ID));

  assign orphan = (state_q == ST_IDLE)  && ((wtype == TYPE_MIDDLE) || (wtype == TYPE_LAST));
  assign trunc  = (state_q == ST_FRAME) && ((wtype == TYPE_SINGLE) || (wtype == TYPE_FIRST));

  // Orphans are swallowed without storage, so only they bypass the full check.
  assign READY     = match && (orphan || !full);
  assign handshake = VALID && READY;
  assign push      = handshake && !orphan;
  assign pop       = RVALID && RREADY;
  assign RVALID    = !empty;
  assign ERR_CNT   = err_q;

  // Next frame state for the word currently offered.
  always_comb begin
    state_d = state_q;
    if (handshake) begin
      unique case (wtype)
        TYPE_SINGLE: state_d = ST_IDLE;
        TYPE_FIRST:  state_d = ST_FRAME;
        TYPE_MIDDLE: state_d = state_q;
        TYPE_LAST:   state_d = ST_IDLE;
        default:     state_d = state_q;
      endcase
    end
  end

  // Frame state register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Saturating protocol-error counter.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      err_q <= '0;
    end else if (handshake && (orphan || trunc) && (err_q != '1)) begin
      err_q <= err_q + 8'd1;
    end
  end

  net_bus_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RSTN),
    .push  (push),
    .wdata (DATA),
    .pop   (pop),
    .rdata (RDATA),
    .full  (full),
    .empty (empty),
    .level (LEVEL)
  );

endmodule

// File: tb/tb_net_bus_rx_node.sv
// Randomised and directed bench for net_bus_rx_node against a queue-based
// reference model of the receive endpoint.
module tb_net_bus_rx_node;

  localparam int unsigned DW    = 4;
  localparam int unsigned W     = DW * 9 + 14;
  localparam int unsigned DEPTH = 8;
  localparam logic [3:0]  NID   = 4'd3;

  logic                      CLK;
  logic                      RSTN;
  logic [W-1:0]              DATA;
  logic                      VALID;
  logic                      READY;
  logic [W-1:0]              RDATA;
  logic                      RVALID;
  logic                      RREADY;
  logic [7:0]                ERR_CNT;
  logic [$clog2(DEPTH):0]    LEVEL;

  net_bus_rx_node #(
    .DATA_WIDTH (DW),
    .NODE_ID    (NID),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .DATA    (DATA),
    .VALID   (VALID),
    .READY   (READY),
    .RDATA   (RDATA),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .ERR_CNT (ERR_CNT),
    .LEVEL   (LEVEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_last;
  bit           m_in_frame;
  int           m_errs;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [3:0] dest, input logic [1:0] typ,
                                      input logic [35:0] pay);
    logic [3:0] src;
    logic [3:0] rsvd;
    src  = 4'h9;
    rsvd = 4'h6;
    return {pay, rsvd, typ, src, dest};
  endfunction

  // One bus cycle: drive, check observable state against the model, clock it.
  task automatic step(input logic [W-1:0] d, input logic v, input logic rr);
    logic [3:0] dest;
    logic [1:0] typ;
    bit         exp_match;
    bit         exp_orph;
    bit         exp_trunc;
    bit         exp_ready;
    bit         popping;
    @(negedge CLK);
    DATA   = d;
    VALID  = v;
    RREADY = rr;
    #1;
    dest      = d[3:0];
    typ       = d[9:8];
    exp_match = v && (dest == NID || dest == 4'hF);
    exp_orph  = !m_in_frame && (typ == 2'd2 || typ == 2'd3);
    exp_trunc = m_in_frame && (typ == 2'd0 || typ == 2'd1);
    exp_ready = exp_match && (exp_orph || m_q.size() < DEPTH);
    check_val("ready", 64'(READY), 64'(exp_ready));
    check_val("level", 64'(LEVEL), 64'(m_q.size()));
    check_val("rvalid", 64'(RVALID), 64'(m_q.size() != 0));
    check_val("err_cnt", 64'(ERR_CNT), 64'(m_errs));
    if (m_q.size() != 0) m_last = m_q[0];
    check_val("rdata", RDATA, m_last);
    popping = (m_q.size() != 0) && rr;
    @(posedge CLK);
    if (popping) void'(m_q.pop_front());
    if (exp_ready) begin
      if (!exp_orph) m_q.push_back(d);
      if ((exp_orph || exp_trunc) && m_errs < 255) m_errs++;
      m_in_frame = (typ == 2'd1) || (m_in_frame && typ == 2'd2);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    VALID  = 1'b0;
    RREADY = 1'b0;
    #2 RSTN = 1'b0;
    #1;
    check_val("rst_ready", 64'(READY), 64'd0);
    check_val("rst_rvalid", 64'(RVALID), 64'd0);
    check_val("rst_rdata", RDATA, 64'd0);
    check_val("rst_err", 64'(ERR_CNT), 64'd0);
    check_val("rst_level", 64'(LEVEL), 64'd0);
    m_q.delete();
    m_last     = '0;
    m_in_frame = 0;
    m_errs     = 0;
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step('0, 1'b0, rr);
  endtask

  initial begin
    logic [35:0] a5;
    logic [W-1:0] w;
    logic [3:0]   dsel;
    a5     = {4{9'h0A5}};
    RSTN   = 1'b1;
    DATA   = '0;
    VALID  = 1'b0;
    RREADY = 1'b0;
    m_last = '0;
    m_in_frame = 0;
    m_errs = 0;
    do_reset();

    // Single word to own address, fall-through visible next cycle.
    step(mk(4'd3, 2'd0, a5), 1'b1, 1'b1);
    step('0, 1'b0, 1'b1);
    idle(1, 1'b1);

    // Foreign address ignored, broadcast accepted.
    step(mk(4'd5, 2'd0, a5), 1'b1, 1'b0);
    step(mk(4'd15, 2'd0, ~a5), 1'b1, 1'b0);
    idle(2, 1'b1);

    // Full frame buffered, then drained in order.
    step(mk(4'd3, 2'd1, 36'h1), 1'b1, 1'b0);
    step(mk(4'd3, 2'd2, 36'h2), 1'b1, 1'b0);
    step(mk(4'd3, 2'd2, 36'h3), 1'b1, 1'b0);
    step(mk(4'd3, 2'd3, 36'h4), 1'b1, 1'b0);
    idle(5, 1'b1);

    // Orphan LAST, then truncated frame FIRST + SINGLE.
    step(mk(4'd3, 2'd3, 36'h5), 1'b1, 1'b0);
    step(mk(4'd3, 2'd1, 36'h6), 1'b1, 1'b0);
    step(mk(4'd3, 2'd0, 36'h7), 1'b1, 1'b0);
    idle(3, 1'b1);

    // Fill to capacity; the ninth word stalls, a pop frees space next cycle.
    for (int i = 0; i < 9; i++) step(mk(4'd3, 2'd0, 36'(i + 16)), 1'b1, 1'b0);
    w = mk(4'd3, 2'd0, 36'd24);
    step(w, 1'b1, 1'b1);
    step(w, 1'b1, 1'b0);
    idle(1, 1'b0);
    idle(9, 1'b1);

    // Reset in the middle of a frame.
    step(mk(4'd3, 2'd1, 36'h30), 1'b1, 1'b0);
    step(mk(4'd3, 2'd2, 36'h31), 1'b1, 1'b0);
    step(mk(4'd3, 2'd2, 36'h32), 1'b1, 1'b0);
    idle(1, 1'b0);
    do_reset();
    step(mk(4'd3, 2'd2, 36'h33), 1'b1, 1'b0);
    idle(1, 1'b0);

    // Error counter saturation via a stream of orphans.
    for (int i = 0; i < 260; i++) step(mk(4'd15, 2'd3, 36'(i)), 1'b1, 1'b0);
    idle(1, 1'b0);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       dsel = 4'd3;
        1:       dsel = 4'hF;
        2:       dsel = 4'd5;
        default: dsel = 4'($urandom);
      endcase
      w = mk(dsel, 2'($urandom), {4'($urandom), 32'($urandom)});
      step(w, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
    end
    idle(10, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
